// File: rtl/au_inc_c_seq.sv
// rtl/au_inc_c_seq.sv - segment-serial incrementer {co, z} = a + ci, SEGW bits per cycle.
// Optional early completion when the carry dies: define AU_INC_EARLY_EXIT_EN.
module au_inc_c_seq #(
    parameter int WIDTH = 8,
    parameter int SEGW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             co
);

    localparam int NSEG = (WIDTH + SEGW - 1) / SEGW;
    localparam int TOPW = WIDTH - (NSEG - 1) * SEGW;
    localparam int IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEGW{1'b1}});

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [IDXW-1:0] idx;
    logic            carry;
    logic            in_ready_r;

    logic [SEGW-1:0]  seg;
    logic [SEGW:0]    seg_sum;
    logic             seg_co;
    logic             last_seg;
    logic             finish_now;
    logic [WIDTH-1:0] z_upd;
    int               off;

    assign in_ready = in_ready_r & ~rst;

    always_comb begin
        off      = int'(idx) * SEGW;
        seg      = SEGW'(z >> off);
        seg_sum  = {1'b0, seg} + {{SEGW{1'b0}}, carry};
        last_seg = (int'(idx) == NSEG - 1);
        // The top segment may be partial: its carry leaves from bit WIDTH-1.
        seg_co   = last_seg ? seg_sum[TOPW] : seg_sum[SEGW];
        z_upd    = (z & ~(SEG_MASK << off)) | (WIDTH'(seg_sum[SEGW-1:0]) << off);
`ifdef AU_INC_EARLY_EXIT_EN
        finish_now = last_seg | ~seg_co;
`else
        finish_now = last_seg;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            z          <= '0;
            co         <= 1'b0;
            out_valid  <= 1'b0;
            idx        <= '0;
            carry      <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        z          <= a;
                        carry      <= ci;
                        idx        <= '0;
                        in_ready_r <= 1'b0;
`ifdef AU_INC_EARLY_EXIT_EN
                        if (!ci) begin
                            co        <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    z     <= z_upd;
                    carry <= seg_co;
                    idx   <= idx + IDXW'(1);
                    if (finish_now) begin
                        co        <= seg_co;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        in_ready_r <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_au_inc_c_seq.sv
// tb/tb_au_inc_c_seq.sv - randomized self-checking bench for au_inc_c_seq (8/2 and 7/3 instances).
module tb_au_inc_c_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] iv, ordy, civ;
    logic [7:0] a0;
    logic [6:0] a1;
    logic       ir0, ir1, ov0, ov1, co0, co1;
    logic [7:0] z0;
    logic [6:0] z1;
    logic       sel;

    wire [7:0] z_s  = sel ? {1'b0, z1} : z0;
    wire       ir_s = sel ? ir1 : ir0;
    wire       ov_s = sel ? ov1 : ov0;
    wire       co_s = sel ? co1 : co0;

    int checks = 0;
    int errors = 0;

    au_inc_c_seq #(.WIDTH(8), .SEGW(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .a(a0), .ci(civ[0]),
        .out_valid(ov0), .out_ready(ordy[0]), .z(z0), .co(co0)
    );

    au_inc_c_seq #(.WIDTH(7), .SEGW(3)) dut7 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .a(a1), .ci(civ[1]),
        .out_valid(ov1), .out_ready(ordy[1]), .z(z1), .co(co1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer addition; latency from the count of trailing ones.
    task automatic model(input int w, input int sw, input logic [7:0] av, input logic c,
                         output logic [7:0] ez, output logic eco, output int lat);
        logic [8:0] s;
        int nseg;
        int t;
        s    = {1'b0, av} + 9'(c);
        ez   = s[7:0] & 8'((1 << w) - 1);
        eco  = s[w];
        nseg = (w + sw - 1) / sw;
        lat  = nseg + 1;
        t    = 0;
`ifdef AU_INC_EARLY_EXIT_EN
        if (!c) lat = 1;
        else if (!eco) begin
            while (av[t]) t++;
            lat = t / sw + 2;
        end
`endif
    endtask

    task automatic drive_a(input logic w, input logic [7:0] v);
        if (w) a1 = v[6:0];
        else   a0 = v;
    endtask

    task automatic run_op(input logic w, input logic [7:0] av_in, input logic c, input int stall);
        logic [7:0] av, ez;
        logic eco;
        int lat, n;
        sel = w;
        av  = w ? (av_in & 8'h7F) : av_in;
        model(w ? 7 : 8, w ? 3 : 2, av, c, ez, eco, lat);
        n = 0;
        while (!ir_s && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", ir_s, 1);
        drive_a(w, av);
        civ[w]  = c;
        iv[w]   = 1'b1;
        ordy[w] = 1'b0;
        @(negedge clk);
        iv[w] = 1'b0;
        drive_a(w, 8'($urandom));
        civ[w] = 1'($urandom);
        n = 1;
        while (!ov_s && n < 30) begin
            check("in_ready_busy", ir_s, 0);
            @(negedge clk);
            n++;
        end
        check("latency", n, lat);
        check("z", z_s, ez);
        check("co", co_s, eco);
        repeat (stall) begin
            iv[w] = 1'($urandom);
            drive_a(w, 8'h11);
            @(negedge clk);
            check("hold_valid", ov_s, 1);
            check("hold_z", z_s, ez);
            check("hold_co", co_s, eco);
            check("hold_in_ready", ir_s, 0);
        end
        iv[w]   = 1'b0;
        ordy[w] = 1'b1;
        @(negedge clk);
        ordy[w] = 1'b0;
        check("valid_drop", ov_s, 0);
        check("in_ready_back", ir_s, 1);
    endtask

    initial begin
        rst = 1'b1; iv = '0; ordy = '0; civ = '0; a0 = '0; a1 = '0; sel = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_z8", z0, 0);
        check("rst_co8", co0, 0);
        check("rst_ov8", ov0, 0);
        check("rst_ir8", ir0, 0);
        check("rst_z7", z1, 0);
        check("rst_ov7", ov1, 0);
        check("rst_ir7", ir1, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ir8", ir0, 1);
        check("post_rst_ir7", ir1, 1);

        run_op(1'b0, 8'hFF, 1'b1, 0);
        run_op(1'b0, 8'h0F, 1'b1, 0);
        run_op(1'b0, 8'h3A, 1'b0, 0);
        run_op(1'b0, 8'h7F, 1'b1, 3);

        // Reset in cycle T+2 of an operation aborts it.
        sel = 1'b0;
        a0 = 8'hFF; civ[0] = 1'b1; iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ov", ov0, 0);
        check("abort_z", z0, 0);
        check("abort_co", co0, 0);
        check("abort_ir_in_rst", ir0, 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ir", ir0, 1);
        run_op(1'b0, 8'h01, 1'b1, 0);

        run_op(1'b1, 8'h7F, 1'b1, 0);
        run_op(1'b1, 8'h3F, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            logic w;
            logic [7:0] v;
            w = 1'($urandom);
            v = 8'($urandom);
            if ($urandom_range(0, 3) == 0) v = 8'hFF;
            run_op(w, v, $urandom_range(0, 3) != 0, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
